// File: rtl/traffic_light_controller_pkg.sv
// Shared types for the stoplight controller: lamp encodings, phase codes and sizing helpers.
package traffic_light_controller_pkg;

    localparam int unsigned COUNT_W = 5;
    localparam int unsigned DEMAND_W = COUNT_W + 1;

    typedef enum logic [1:0] {
        LIGHT_RED    = 2'b00,
        LIGHT_GREEN  = 2'b01,
        LIGHT_YELLOW = 2'b10
    } light_e;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        RED_TO_EW = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        RED_TO_NS = 3'd5
    } phase_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/traffic_light_controller_if.sv
// Sensor-side counts/flag in, lamp state and per-axis go strobes out.
// Signalling is level-based and sampled every cycle: no valid/ready, the controller
// reads counts live and the sensor side may release cars on an axis while its go is high.
interface traffic_light_controller_if;
    import traffic_light_controller_pkg::*;

    logic [COUNT_W-1:0] n_counter;
    logic [COUNT_W-1:0] s_counter;
    logic [COUNT_W-1:0] e_counter;
    logic [COUNT_W-1:0] w_counter;
    logic               high_low;
    logic [1:0]         ns_light;
    logic [1:0]         ew_light;
    logic               ns_go;
    logic               ew_go;
    logic [2:0]         phase;

    modport master (
        output n_counter, s_counter, e_counter, w_counter, high_low,
        input  ns_light, ew_light, ns_go, ew_go, phase
    );

    modport slave (
        input  n_counter, s_counter, e_counter, w_counter, high_low,
        output ns_light, ew_light, ns_go, ew_go, phase
    );

endinterface

// File: rtl/traffic_light_controller_phase_timer.sv
// Phase duration counter: cleared on state entry, counts up, flags the last cycle of a phase.
module traffic_light_controller_phase_timer #(
    parameter int unsigned W = 5
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic [W-1:0] count_o,
    output logic         hit_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;
    assign hit_o   = (count_q == (limit_i - W'(1)));

endmodule

// File: rtl/traffic_light_controller.sv
// N/S vs E/W signal-phase FSM with demand-driven early cut, green rest and all-red clearance.
module traffic_light_controller
    import traffic_light_controller_pkg::*;
#(
    parameter int unsigned GREEN_LOW  = 8,
    parameter int unsigned GREEN_HIGH = 16,
    parameter int unsigned MIN_GREEN  = 4,
    parameter int unsigned YELLOW     = 3,
    parameter int unsigned ALL_RED    = 2
) (
    input  logic                        CLK,
    input  logic                        rst,
    traffic_light_controller_if.slave   bus
);

    localparam int unsigned TW = $clog2(max3(GREEN_HIGH, YELLOW, ALL_RED)) + 1;
    localparam logic [TW-1:0] MIN_CUT = TW'(MIN_GREEN - 1);

    phase_e                state_q, state_d;
    logic [TW-1:0]         g_q, g_d;
    logic [TW-1:0]         limit;
    logic [TW-1:0]         timer;
    logic                  hit;
    logic                  rest;
    logic                  clr;
    logic [DEMAND_W-1:0]   nsd, ewd;

    assign nsd = {1'b0, bus.n_counter} + {1'b0, bus.s_counter};
    assign ewd = {1'b0, bus.e_counter} + {1'b0, bus.w_counter};

    always_comb begin
        state_d = state_q;
        rest    = 1'b0;
        case (state_q)
            NS_GREEN: begin
                if (ewd != '0 && (hit || (timer >= MIN_CUT && nsd == '0))) begin
                    state_d = NS_YELLOW;
                end else if (hit) begin
                    rest = 1'b1;
                end
            end
            NS_YELLOW: if (hit) state_d = RED_TO_EW;
            RED_TO_EW: if (hit) state_d = (ewd == '0 && nsd != '0) ? NS_GREEN : EW_GREEN;
            EW_GREEN: begin
                if (nsd != '0 && (hit || (timer >= MIN_CUT && ewd == '0))) begin
                    state_d = EW_YELLOW;
                end else if (hit) begin
                    rest = 1'b1;
                end
            end
            EW_YELLOW: if (hit) state_d = RED_TO_NS;
            RED_TO_NS: if (hit) state_d = (nsd == '0 && ewd != '0) ? EW_GREEN : NS_GREEN;
            default:   state_d = RED_TO_NS;
        endcase
    end

    // Any state entry (including a green rest) restarts the timer and re-latches G.
    assign clr = rst || rest || (state_d != state_q);
    assign g_d = bus.high_low ? TW'(GREEN_HIGH) : TW'(GREEN_LOW);

    always_comb begin
        limit = TW'(1);
        case (state_q)
            NS_GREEN, EW_GREEN:   limit = g_q;
            NS_YELLOW, EW_YELLOW: limit = TW'(YELLOW);
            RED_TO_EW, RED_TO_NS: limit = TW'(ALL_RED);
            default:              limit = TW'(1);
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= RED_TO_NS;
            g_q     <= TW'(GREEN_LOW);
        end else begin
            state_q <= state_d;
            if (clr && (state_d == NS_GREEN || state_d == EW_GREEN)) begin
                g_q <= g_d;
            end
        end
    end

    traffic_light_controller_phase_timer #(
        .W (TW)
    ) u_timer (
        .clk_i   (CLK),
        .clr_i   (clr),
        .en_i    (1'b1),
        .limit_i (limit),
        .count_o (timer),
        .hit_o   (hit)
    );

    always_comb begin
        bus.ns_light = LIGHT_RED;
        bus.ew_light = LIGHT_RED;
        case (state_q)
            NS_GREEN:  bus.ns_light = LIGHT_GREEN;
            NS_YELLOW: bus.ns_light = LIGHT_YELLOW;
            EW_GREEN:  bus.ew_light = LIGHT_GREEN;
            EW_YELLOW: bus.ew_light = LIGHT_YELLOW;
            default: begin
                bus.ns_light = LIGHT_RED;
                bus.ew_light = LIGHT_RED;
            end
        endcase
    end

    assign bus.ns_go = (state_q == NS_GREEN);
    assign bus.ew_go = (state_q == EW_GREEN);
    assign bus.phase = state_q;

endmodule
